// File: rtl/booth_mul_if.sv
// Operand/result bundle between the control sequencer and the Booth multiplier.
interface booth_mul_if #(
    parameter int WIDTH = 32
);
    logic                      start;
    logic signed [WIDTH-1:0]   multiplicand;
    logic signed [WIDTH-1:0]   multiplier;
    logic                      busy;
    logic                      finished;
    logic signed [2*WIDTH-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, finished, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, finished, product
    );
endinterface

// File: rtl/booth_mul_unit.sv
// Sequential signed multiplier, radix-4 Booth recoding, two multiplier bits per clock.
// WIDTH must be even and at least 4; the product is 2*WIDTH bits.
module booth_mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic        Clock,
    input  logic        clear,
    booth_mul_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH / 2 + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Accumulator carries two guard bits so that +/-2M never overflows.
    logic signed [WIDTH+1:0]   acc_q, acc_d;
    logic        [WIDTH-1:0]   q_q, q_d;
    logic                      qm1_q, qm1_d;
    logic signed [WIDTH-1:0]   m_q, m_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [2*WIDTH-1:0] prod_q, prod_d;
    logic signed [WIDTH+1:0]   sum;
    logic                      last_step;
    logic                      busy_o, finished_o;

    // Partial product selected by the Booth triple {q1, q0, q-1}.
    function automatic logic signed [WIDTH+1:0] booth_pp(
        input logic [2:0]              trip,
        input logic signed [WIDTH-1:0] m
    );
        logic signed [WIDTH+1:0] m_ext;
        m_ext = {{2{m[WIDTH-1]}}, m};
        case (trip)
            3'b001, 3'b010: return m_ext;
            3'b011:         return m_ext <<< 1;
            3'b100:         return -(m_ext <<< 1);
            3'b101, 3'b110: return -m_ext;
            default:        return '0;
        endcase
    endfunction

    assign last_step = (cnt_q == LAST_STEP);

    // FSM state register; clear aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state: DONE accepts a new start directly (back-to-back).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy during RUN, finished for the single DONE cycle.
    always_comb begin
        busy_o     = (state_q == S_RUN);
        finished_o = (state_q == S_DONE);
    end

    // Datapath next-state: latch operands on accept, one Booth step per RUN cycle.
    always_comb begin
        m_d    = m_q;
        acc_d  = acc_q;
        q_d    = q_q;
        qm1_d  = qm1_q;
        cnt_d  = cnt_q;
        prod_d = prod_q;
        sum    = '0;
        if (state_q == S_RUN) begin
            sum   = acc_q + booth_pp({q_q[1:0], qm1_q}, m_q);
            acc_d = sum >>> 2;
            q_d   = {sum[1:0], q_q[WIDTH-1:2]};
            qm1_d = q_q[1];
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) prod_d = {acc_d[WIDTH-1:0], q_d};
        end else if (bus.start) begin
            m_d   = bus.multiplicand;
            q_d   = bus.multiplier;
            acc_d = '0;
            qm1_d = 1'b0;
            cnt_d = '0;
        end
    end

    // Datapath registers; clear zeroes everything so no X reaches the outputs.
    always_ff @(posedge Clock) begin
        if (clear) begin
            m_q    <= '0;
            acc_q  <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            cnt_q  <= '0;
            prod_q <= '0;
        end else begin
            m_q    <= m_d;
            acc_q  <= acc_d;
            q_q    <= q_d;
            qm1_q  <= qm1_d;
            cnt_q  <= cnt_d;
            prod_q <= prod_d;
        end
    end

    assign bus.busy     = busy_o;
    assign bus.finished = finished_o;
    assign bus.product  = prod_q;

endmodule

// File: tb/tb_booth_mul_unit.sv
// Directed and randomised checks of booth_mul_unit at WIDTH=32.
module tb_booth_mul_unit;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_errors = 0;
    int   fin_cnt  = 0;

    always #5 clk = ~clk;

    booth_mul_if #(.WIDTH(32)) bus ();

    booth_mul_unit #(.WIDTH(32)) dut (
        .Clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always @(negedge clk) if (!clear && bus.finished === 1'b1) fin_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble operands after the latch edge, wait for finished.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp, input string tag, input bit full);
        int          cyc;
        int          nbusy;
        logic [63:0] hold;
        hold = bus.product;
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        tick();
        bus.start = 1'b0;
        bus.multiplicand = ~m;
        bus.multiplier = q ^ 32'h5A5A_5A5A;
        cyc = 0;
        nbusy = 0;
        while (bus.finished !== 1'b1 && cyc < 40) begin
            if (bus.busy === 1'b1) nbusy++;
            if (full && cyc == 8) chk({tag, "_hold"}, bus.product, hold);
            tick();
            cyc++;
        end
        if (full) begin
            chk({tag, "_lat"}, 64'(cyc), 64'd16);
            chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd16);
        end
        chk({tag, "_prod"}, bus.product, exp);
        tick();
        if (full) begin
            chk({tag, "_fin_low"}, 64'(bus.finished), 64'd0);
            chk({tag, "_prod_stable"}, bus.product, exp);
        end
    endtask

    initial begin
        int          cyc;
        int          fin_base;
        logic [31:0] rm, rq;
        logic [63:0] rexp;

        clear = 1'b1;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        tick();
        tick();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_fin", 64'(bus.finished), 64'd0);
        chk("rst_prod", bus.product, 64'd0);
        clear = 1'b0;
        tick();

        run_op(32'h1000_000F, 32'h0000_0020, 64'h0000_0002_0000_01E0, "basic", 1'b1);
        run_op(32'hFFFF_FFF9, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFEB, "neg7x3", 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, "m1xm1", 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "minxmin", 1'b1);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "maxxmin", 1'b1);
        run_op(32'h0000_0000, 32'h1234_5678, 64'h0, "zero_m", 1'b1);
        run_op(32'h0000_0009, 32'h0000_000B, 64'd99, "nine_x_eleven", 1'b1);
        run_op(32'h1234_5678, 32'h0000_0000, 64'h0, "zero_q", 1'b1);

        // Back-to-back: start held high, next pair latched in the DONE cycle.
        bus.start = 1'b1;
        bus.multiplicand = 32'd3;
        bus.multiplier = 32'd5;
        tick();
        bus.multiplicand = 32'd7;
        bus.multiplier = 32'd11;
        cyc = 0;
        while (bus.finished !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("b2b_lat1", 64'(cyc), 64'd16);
        chk("b2b_prod1", bus.product, 64'd15);
        tick();
        bus.multiplicand = 32'h100;
        bus.multiplier = 32'h100;
        chk("b2b_fin_low", 64'(bus.finished), 64'd0);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        cyc = 1;
        while (bus.finished !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        chk("b2b_period", 64'(cyc), 64'd17);
        chk("b2b_prod2", bus.product, 64'd77);
        bus.start = 1'b0;
        tick();
        chk("b2b_end_fin", 64'(bus.finished), 64'd0);
        chk("b2b_end_busy", 64'(bus.busy), 64'd0);

        // Clear in the middle of a run.
        bus.start = 1'b1;
        bus.multiplicand = 32'h0BAD_BEEF;
        bus.multiplier = 32'h1357_9BDF;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        clear = 1'b1;
        tick();
        chk("clr_busy", 64'(bus.busy), 64'd0);
        chk("clr_fin", 64'(bus.finished), 64'd0);
        chk("clr_prod", bus.product, 64'd0);
        clear = 1'b0;
        run_op(32'd5, 32'd6, 64'd30, "after_clr", 1'b1);

        // Randomised signed pairs against a 64-bit reference multiply.
        fin_base = fin_cnt;
        for (int i = 0; i < 1000; i++) begin
            rm = $urandom;
            rq = $urandom;
            if (i % 8 == 0) rm = {rm[31], 31'h0};
            rexp = $signed(64'($signed(rm))) * $signed(64'($signed(rq)));
            run_op(rm, rq, rexp, "rand", 1'b0);
        end
        chk("rand_fin_count", 64'(fin_cnt - fin_base), 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
